// File: rtl/pwm_fade_pkg.sv
// Shared types and helpers for the LED fade sequencer.
// Build option: PWM_FADE_LOOP_EN (continuous breathing instead of single shot).
package pwm_fade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } fade_state_t;

  function automatic logic [31:0] level_max(input int ctr_len);
    if (ctr_len >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << ctr_len) - 32'd1;
  endfunction

  function automatic logic [31:0] clip(input logic [31:0] level, input logic [31:0] ceiling);
    return (level < ceiling) ? level : ceiling;
  endfunction

endpackage

// File: rtl/pwm_fade_tick.sv
// Ramp-step prescaler: pulses tick once every TICK_DIV enabled cycles.
module pwm_fade_tick #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] prescaler_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prescaler_reg <= '0;
    end else if (clr) begin
      prescaler_reg <= '0;
    end else if (en) begin
      prescaler_reg <= (prescaler_reg == CNT_LAST) ? '0 : prescaler_reg + CNT_W'(1);
    end
  end

  assign tick = en && (prescaler_reg == CNT_LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer: one shared level ramps up/holds/down, clipped per channel to a ceiling.
// Build option: PWM_FADE_LOOP_EN restarts the ramp after each completed cycle.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int CTR_LEN    = 8,
  parameter int TICK_DIV   = 1024,
  parameter int HOLD_STEPS = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0]   cfg_ch,
  input  logic [CTR_LEN-1:0]          cfg_max,
  output logic [NUM_CH*CTR_LEN-1:0]   compare,
  output logic                        busy,
  output logic                        done
);

  localparam logic [CTR_LEN-1:0] LEVEL_MAX = CTR_LEN'(level_max(CTR_LEN));
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  fade_state_t         state_reg;
  logic [CTR_LEN-1:0]  level_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                cfg_ready_reg;
  logic                tick;

  pwm_fade_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rstn(rstn),
    .en  (busy_reg),
    .clr ((state_reg == IDLE) || stop),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      level_reg     <= '0;
      hold_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cfg_ready_reg <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      // Abort wins over any tick landing in the same cycle.
      if (stop && (state_reg != IDLE)) begin
        state_reg     <= IDLE;
        level_reg     <= '0;
        hold_cnt_reg  <= '0;
        busy_reg      <= 1'b0;
        cfg_ready_reg <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && !stop) begin
              state_reg     <= UP;
              hold_cnt_reg  <= '0;
              busy_reg      <= 1'b1;
              cfg_ready_reg <= 1'b0;
            end
          end
          UP: begin
            if (tick) begin
              if (level_reg == LEVEL_MAX) state_reg <= HOLD;
              else                        level_reg <= level_reg + CTR_LEN'(1);
            end
          end
          HOLD: begin
            if (tick) begin
              if (hold_cnt_reg == HOLD_LAST) begin
                state_reg    <= DOWN;
                hold_cnt_reg <= '0;
              end else begin
                hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
              end
            end
          end
          DOWN: begin
            if (tick) begin
              if (level_reg <= CTR_LEN'(1)) begin
                level_reg <= '0;
                done_reg  <= 1'b1;
`ifdef PWM_FADE_LOOP_EN
                state_reg <= UP;
`else
                state_reg     <= IDLE;
                busy_reg      <= 1'b0;
                cfg_ready_reg <= 1'b1;
`endif
              end else begin
                level_reg <= level_reg - CTR_LEN'(1);
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CTR_LEN-1:0] ceil_reg;
      logic [CTR_LEN-1:0] cmp_reg;

      // Out-of-range channel indices match no slice, so the write is dropped.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          ceil_reg <= LEVEL_MAX;
          cmp_reg  <= '0;
        end else begin
          if (cfg_valid && cfg_ready_reg && (32'(cfg_ch) == gi)) ceil_reg <= cfg_max;
          cmp_reg <= CTR_LEN'(clip(32'(level_reg), 32'(ceil_reg)));
        end
      end

      assign compare[gi*CTR_LEN +: CTR_LEN] = cmp_reg;
    end
  endgenerate

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign cfg_ready = cfg_ready_reg;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl (NUM_CH=8, CTR_LEN=3, TICK_DIV=4, HOLD_STEPS=2).
module tb_pwm_fade_ctrl;

  localparam int NUM_CH = 8;
  localparam int CTR_LEN = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_ch = '0;
  logic [2:0]  cfg_max = '0;
  logic [23:0] compare;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int cexp [NUM_CH];

  pwm_fade_ctrl #(
    .NUM_CH(NUM_CH), .CTR_LEN(CTR_LEN), .TICK_DIV(4), .HOLD_STEPS(2)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_max(cfg_max),
    .compare(compare), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Level after k ticks of a single-shot sequence: 7 up, 1 turn, 2 hold, 7 down.
  function automatic int exp_level(input int k);
    if (k <= 7)  return k;
    if (k <= 10) return 7;
    if (k <= 17) return 17 - k;
    return 0;
  endfunction

  function automatic logic [23:0] exp_cmp(input int lvl);
    logic [23:0] r;
    int v;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      v = (lvl < cexp[i]) ? lvl : cexp[i];
      r[i*CTR_LEN +: CTR_LEN] = 3'(v);
    end
    return r;
  endfunction

  task automatic cfg_write(input int ch, input int mx);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_max   = 3'(mx);
    $display("cfg write ch=%0d max=%0d ready=%0b", ch, mx, cfg_ready);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    $display("start pulse");
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    $display("stop pulse");
    step();
    stop = 1'b0;
  endtask

  initial begin
    int done_cnt;
    for (int i = 0; i < NUM_CH; i++) cexp[i] = 7;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_compare", 32'(compare), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
    #2 rstn = 1'b1;
    step();

    cfg_write(2, 3); cexp[2] = 3;
    cfg_write(5, 0); cexp[5] = 0;
    pulse_start();
    chk("start_busy", 32'(busy), 32'h1);

`ifdef PWM_FADE_LOOP_EN
    done_cnt = 0;
    for (int n = 1; n <= 204; n++) begin
      step();
      if (done) done_cnt++;
      if (n % 17 == 0) chk("loop_busy", 32'(busy), 32'h1);
      if (n == 68 || n == 136 || n == 204) chk("loop_done_at_end", 32'(done), 32'h1);
    end
    chk("loop_done_cnt", 32'(done_cnt), 32'd3);
    $display("loop: %0d cycles completed", done_cnt);
    pulse_stop();
    chk("loop_stop_busy", 32'(busy), 32'h0);
    chk("loop_stop_done", 32'(done), 32'h0);
    step();
    chk("loop_stop_done2", 32'(done), 32'h0);
`else
    // Full single-shot sequence, with a refused config write during UP
    for (int n = 1; n <= 69; n++) begin
      if (n == 10) begin
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_max = 3'd2;
        chk("cfg_ready_busy", 32'(cfg_ready), 32'h0);
      end
      step();
      cfg_valid = 1'b0;
      chk("seq_compare", 32'(compare), 32'(exp_cmp(exp_level((n - 1) / 4))));
      chk("seq_busy", 32'(busy), 32'(n < 68));
      chk("seq_done", 32'(done), 32'(n == 68));
    end
    chk("seq_cfg_ready_end", 32'(cfg_ready), 32'h1);
    $display("single-shot sequence complete");
`endif

    // Abort at level 4 during UP
    pulse_start();
    done_cnt = 0;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (done) done_cnt++;
    end
    chk("abort_pre_compare", 32'(compare), 32'(exp_cmp(3)));
    pulse_stop();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_compare_lag", 32'(compare), 32'(exp_cmp(4)));
    if (done) done_cnt++;
    step();
    chk("abort_compare_zero", 32'(compare), 32'h0);
    if (done) done_cnt++;
    chk("abort_no_done", 32'(done_cnt), 32'h0);

    // Start and stop together in IDLE: nothing happens; lone stop in IDLE likewise
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 32'(busy), 32'h0);
    pulse_stop();
    chk("stop_idle", 32'(busy), 32'h0);

    // Replay from 0, config write in the same cycle as start is applied
    cfg_valid = 1'b1; cfg_ch = 3'd7; cfg_max = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0; cfg_valid = 1'b0;
    cexp[7] = 0;
    for (int n = 1; n <= 5; n++) begin
      step();
      if (n == 4) chk("replay_from_zero", 32'(compare), 32'h0);
      if (n == 5) chk("replay_first_step", 32'(compare), 32'(exp_cmp(1)));
    end
    pulse_stop();

    // Asynchronous reset mid-HOLD
    pulse_start();
    repeat (34) step();
    chk("hold_compare", 32'(compare), 32'(exp_cmp(7)));
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_compare", 32'(compare), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_cfg_ready", 32'(cfg_ready), 32'h1);
    @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < NUM_CH; i++) cexp[i] = 7;
    step();
    pulse_start();
    repeat (29) step();
    chk("post_rst_ceilings", 32'(compare), 32'(exp_cmp(7)));
    pulse_stop();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Sequencer that drives the `compare` inputs of a bank of NUM_CH `pwm` channels to produce an LED fade (breathing) pattern.
- A single shared brightness level ramps up, holds, then ramps down. Each channel's compare output is that level clipped to a per-channel ceiling.
- Ceilings are written over a valid/ready config port while idle.
- Sits between the clock-divider logic and the `pwm` instances, in the `clk` domain.

Parameters:
- NUM_CH, 8, number of PWM channels driven.
- CTR_LEN, 8, duty/compare width; must match the `pwm` CTR_LEN.
- TICK_DIV, 1024, clk cycles per ramp step (>=2).
- HOLD_STEPS, 16, ramp steps spent at peak level (>=1).

Ports:
- clk, in, 1, sole clock.
- rstn, in, 1, reset, asynchronous, active-low.
- start, in, 1, single-cycle request to begin a fade sequence.
- stop, in, 1, single-cycle abort.
- cfg_valid, in, 1, config write request.
- cfg_ready, out, 1, config write accepted when high.
- cfg_ch, in, $clog2(NUM_CH), channel index for the config write.
- cfg_max, in, CTR_LEN, ceiling value for channel cfg_ch.
- compare, out, NUM_CH*CTR_LEN, flattened per-channel compare values; channel i is at bits [i*CTR_LEN +: CTR_LEN].
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse when a sequence completes normally.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, level=0, prescaler=0, hold_cnt=0.
  - All ceilings = 2^CTR_LEN-1.
  - compare=0, busy=0, done=0, cfg_ready=1.
- States:
  - IDLE:
    - start=1 -> UP; prescaler and hold_cnt cleared.
    - start and stop in the same cycle -> stay in IDLE.
  - UP: on tick, level+1. If level==2^CTR_LEN-1 at the tick, go to HOLD instead (no increment).
  - HOLD: on tick, hold_cnt+1. When hold_cnt reaches HOLD_STEPS-1 at a tick -> DOWN, hold_cnt=0.
  - DOWN: on tick, level-1. The tick that makes level 0 -> IDLE and done=1 for exactly that next cycle.
- Level arithmetic: no wrap in either direction; saturates at 0 and at 2^CTR_LEN-1.
- Tick:
  - prescaler counts 0..TICK_DIV-1 only while busy.
  - tick = (prescaler==TICK_DIV-1); prescaler wraps to 0.
  - The first tick comes TICK_DIV cycles after start is sampled.
- stop:
  - In UP, HOLD or DOWN: next cycle state=IDLE, level=0, prescaler=0, no done pulse.
  - stop in IDLE has no effect.
  - stop takes priority over a same-cycle tick.
- start while busy is ignored.
- Config port:
  - cfg_ready = (state==IDLE).
  - On cfg_valid && cfg_ready, ceiling[cfg_ch] <= cfg_max.
  - cfg_ch >= NUM_CH: handshake completes, write discarded.
  - A write in the same cycle as start is applied.
- Compare output:
  - compare[i] registered as min(level, ceiling[i]).
  - Latency 1 clk from a level or ceiling change.
  - Ceiling 0 holds that channel dark.
- done is registered and asserted together with the busy 1->0 transition.

Optional Feature:
- PWM_FADE_LOOP_EN defined:
  - DOWN reaching level 0 returns to UP instead of IDLE, and pulses done each cycle completion.
  - Runs until stop or reset; busy stays 1.
- Undefined: single-shot sequence exactly as above.

Decomposition:
- Package pwm_fade_pkg:
  - State enum IDLE/UP/HOLD/DOWN (2-bit).
  - Function computing LEVEL_MAX from CTR_LEN.
  - clip (min) function.
- One sub-module, pwm_fade_tick: prescaler with enable and synchronous clear, outputting tick; parameter TICK_DIV; same clk/rstn.

Test Plan (NUM_CH=8, CTR_LEN=3, TICK_DIV=4, HOLD_STEPS=2 unless noted):
- Reset: rstn low for 3 cycles -> compare=0, busy=0, done=0, cfg_ready=1; ceilings read back as 7 via compare after a full-up sequence.
- Full sequence:
  - Stimulus: write ch2 max=3 and ch5 max=0, then pulse start.
  - First tick at cycle 4 after start. Channels 0,1,3,4,6,7 rise 1..7, one step every 4 clk. ch2 stops at 3; ch5 stays 0.
  - Sequence is 7 up + 1 transition + 2 hold + 7 down ticks. done pulses once, busy falls in the same cycle, compare=0 everywhere one cycle later.
- Config while busy: cfg_valid=1, ch1, max=2 during UP -> cfg_ready=0. Ceiling 1 unchanged; next sequence still reaches 7 on ch1.
- Abort: stop at level=4 in UP -> next cycle busy=0 and level 0; compare=0 one cycle after; done never asserted. A start after this replays from 0.
- Async reset mid-HOLD: drop rstn -> compare=0 and busy=0 immediately, without a clk edge; ceilings back to 7.
- With PWM_FADE_LOOP_EN: start, run 3 full cycles -> done pulses 3 times, busy stays 1. stop -> IDLE; done not pulsed on the stop.
